// File: rtl/selector_casilla.sv
// selector_casilla: debounced cursor movement and single-shot fire control for the 8x8 bomb board
module selector_casilla #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4,
  parameter int MAX_DISPAROS    = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_arriba,
  input  logic            btn_abajo,
  input  logic            btn_izq,
  input  logic            btn_der,
  input  logic            btn_disparo,
  input  logic [7:0][7:0] seleccion_matriz,
  output logic [2:0]      col,
  output logic [2:0]      fila,
  output logic            button_bomba,
  output logic            rechazo,
  output logic [5:0]      disparos,
  output logic            fin_disparos
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = PULSE_CYCLES > 1 ? $clog2(PULSE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, CHECK, PULSE, WAIT_REL} state_t;
  state_t state, state_n;
  logic [4:0] raw, s1, s2, lvl, lvl_d, ev;
  logic [CW-1:0] cnt [5];
  logic [PW-1:0] pcnt, pcnt_n;
  logic [2:0] col_n, fila_n;
  logic [5:0] disp_n;
  logic bomba_n, rech_n;
  // bit order: 0 arriba, 1 abajo, 2 izq, 3 der, 4 disparo
  assign raw = {btn_disparo, btn_der, btn_izq, btn_abajo, btn_arriba};
  assign ev = lvl_d & ~lvl;
  assign fin_disparos = disparos == 6'(MAX_DISPAROS);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '1;
      s2 <= '1;
      lvl <= '1;
      lvl_d <= '1;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_d <= lvl;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      col <= '0;
      fila <= '0;
      button_bomba <= 1'b1;
      rechazo <= 1'b0;
      disparos <= '0;
      pcnt <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      fila <= fila_n;
      button_bomba <= bomba_n;
      rechazo <= rech_n;
      disparos <= disp_n;
      pcnt <= pcnt_n;
    end
  end
  always_comb begin
    state_n = state;
    col_n = col;
    fila_n = fila;
    bomba_n = button_bomba;
    rech_n = 1'b0;
    disp_n = disparos;
    pcnt_n = pcnt;
    unique case (state)
      IDLE: begin
        col_n = col + 3'(ev[3]) - 3'(ev[2]);
        fila_n = fila + 3'(ev[0]) - 3'(ev[1]);
        if (ev[4]) begin
          state_n = fin_disparos ? WAIT_REL : CHECK;
          rech_n = fin_disparos;
        end
      end
      CHECK: begin
        if (seleccion_matriz[col][fila]) begin
          rech_n = 1'b1;
          state_n = WAIT_REL;
        end else begin
          state_n = PULSE;
          bomba_n = 1'b0;
          pcnt_n = '0;
          disp_n = disparos + 6'(!fin_disparos);
        end
      end
      PULSE: begin
        if (pcnt == PW'(PULSE_CYCLES - 1)) begin
          bomba_n = 1'b1;
          state_n = WAIT_REL;
        end else pcnt_n = pcnt + 1'b1;
      end
      WAIT_REL: state_n = lvl[4] ? IDLE : WAIT_REL;
      default: state_n = IDLE;
    endcase
  end
endmodule
